// File: rtl/mult_control_unit.sv
// Control FSM for a 4-bit shift-add multiplier.
// Sequences LOAD, four ADD/SHIFT iterations and DONE, and drives the datapath strobes.
// Offers a Start/Ready/Done handshake to the system.
// Optional watchdog: define MULT_CU_WDOG_EN to add an iteration watchdog and an ERROR state.
module mult_control_unit #(
  parameter int unsigned WDOG_LIMIT = 16  // max ADD+SHIFT cycles per op; must be >= 8
) (
  input  logic CU_Clock,
  input  logic CU_Reset_n,
  input  logic CU_Start,
  input  logic CU_Q_LSB,
  input  logic CU_Cnt_Out,
  output logic CU_Ready,
  output logic CU_Done,
  output logic CU_Error,
  output logic CU_Load_Q,
  output logic CU_Load_R,
  output logic CU_Load_P,
  output logic CU_Load_G,
  output logic CU_Shift,
  output logic CU_Cnt_En,
  output logic CU_Clear
);

`ifdef MULT_CU_WDOG_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StAdd   = 3'd2,
    StShift = 3'd3,
    StDone  = 3'd4,
    StError = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StAdd   = 3'd2,
    StShift = 3'd3,
    StDone  = 3'd4
  } state_e;
`endif

  state_e state_q, state_d;

`ifdef MULT_CU_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             wdog_hit;

  // Current ADD/SHIFT cycle is the WDOG_LIMIT-th one: the counter reaches the limit at this edge.
  assign wdog_hit = (wdog_q >= WdogW'(WDOG_LIMIT - 1));

  // Watchdog next value: cleared by LOAD, counts every ADD and SHIFT cycle.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == StLoad) begin
      wdog_d = '0;
    end else if ((state_q == StAdd) || (state_q == StShift)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge CU_Clock or negedge CU_Reset_n) begin
    if (!CU_Reset_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  // Limit only matters to the watchdog; keep it referenced for lint.
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
`endif

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge CU_Clock or negedge CU_Reset_n) begin
    if (!CU_Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle: begin
        state_d = CU_Start ? StLoad : StIdle;
      end
      StLoad: begin
        state_d = StAdd;
      end
      StAdd: begin
`ifdef MULT_CU_WDOG_EN
        state_d = wdog_hit ? StError : StShift;
`else
        state_d = StShift;
`endif
      end
      StShift: begin
        if (CU_Cnt_Out) begin
          state_d = StDone;
`ifdef MULT_CU_WDOG_EN
        end else if (wdog_hit) begin
          state_d = StError;
`endif
        end else begin
          state_d = StAdd;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
`ifdef MULT_CU_WDOG_EN
      // Start only clears the fault; it does not launch an operation.
      StError: begin
        state_d = CU_Start ? StIdle : StError;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode; only the add strobes look at an input (the multiplier LSB).
  always_comb begin
    CU_Ready  = 1'b0;
    CU_Done   = 1'b0;
    CU_Error  = 1'b0;
    CU_Load_Q = 1'b0;
    CU_Load_R = 1'b0;
    CU_Load_P = 1'b0;
    CU_Load_G = 1'b0;
    CU_Shift  = 1'b0;
    CU_Cnt_En = 1'b0;
    CU_Clear  = 1'b0;
    unique case (state_q)
      StIdle: begin
        CU_Ready = 1'b1;
      end
      StLoad: begin
        CU_Load_Q = 1'b1;
        CU_Load_R = 1'b1;
        CU_Clear  = 1'b1;
      end
      StAdd: begin
        CU_Load_P = CU_Q_LSB;
        CU_Load_G = CU_Q_LSB;
      end
      StShift: begin
        CU_Shift  = 1'b1;
        CU_Cnt_En = 1'b1;
      end
      StDone: begin
        CU_Done = 1'b1;
      end
`ifdef MULT_CU_WDOG_EN
      StError: begin
        CU_Error = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
// Directed self-checking bench for mult_control_unit, with a small shift-add datapath model
// that closes the loop on Q_LSB and Cnt_Out.
module tb_mult_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic q_lsb, cnt_out;
  logic ready, done, error, load_q, load_r, load_p, load_g, shift, cnt_en, clear;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_control_unit #(.WDOG_LIMIT(16)) dut (
    .CU_Clock  (clk),
    .CU_Reset_n(rst_n),
    .CU_Start  (start),
    .CU_Q_LSB  (q_lsb),
    .CU_Cnt_Out(cnt_out),
    .CU_Ready  (ready),
    .CU_Done   (done),
    .CU_Error  (error),
    .CU_Load_Q (load_q),
    .CU_Load_R (load_r),
    .CU_Load_P (load_p),
    .CU_Load_G (load_g),
    .CU_Shift  (shift),
    .CU_Cnt_En (cnt_en),
    .CU_Clear  (clear)
  );

  // Datapath model
  logic [3:0] q_in = 4'h0;
  logic [3:0] r_in = 4'h0;
  logic [3:0] dp_q = 4'h0;
  logic [3:0] dp_r = 4'h0;
  logic [3:0] dp_p = 4'h0;
  logic       dp_c = 1'b0;
  logic [1:0] dp_cnt = 2'd0;
  logic       force_cnt0 = 1'b0;
  logic [4:0] sum;

  assign sum     = {1'b0, dp_p} + {1'b0, dp_r};
  assign q_lsb   = dp_q[0];
  assign cnt_out = force_cnt0 ? 1'b0 : (dp_cnt == 2'd3);

  always @(posedge clk) begin
    if (clear) begin
      dp_p   <= 4'h0;
      dp_c   <= 1'b0;
      dp_cnt <= 2'd0;
    end
    if (load_q) dp_q <= q_in;
    if (load_r) dp_r <= r_in;
    if (load_p) dp_p <= sum[3:0];
    if (load_g) dp_c <= sum[4];
    if (shift) {dp_c, dp_p, dp_q} <= {1'b0, dp_c, dp_p, dp_q[3:1]};
    if (cnt_en) dp_cnt <= dp_cnt + 2'd1;
  end

  logic [8:0] ctl;
  assign ctl = {done, error, load_q, load_r, load_p, load_g, shift, cnt_en, clear};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply launched from IDLE; cycle k=1 is LOAD, k=10 DONE, k=11 Ready.
  task automatic run_op(input string tag, input logic [3:0] q, input logic [3:0] r,
                        input logic [31:0] exp_lp, input logic [7:0] exp_prod);
    logic [31:0] lp, sh, ce, lq, dn, rd;
    int excl;
    lp = 0; sh = 0; ce = 0; lq = 0; dn = 0; rd = 0; excl = 0;
    q_in = q;
    r_in = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (load_p) lp[k] = 1'b1;
      if (shift) sh[k] = 1'b1;
      if (cnt_en) ce[k] = 1'b1;
      if (load_q) lq[k] = 1'b1;
      if (done) dn[k] = 1'b1;
      if (ready) rd[k] = 1'b1;
      if (((load_q | load_r | clear) + (load_p | load_g) + (shift | cnt_en)) > 1) excl++;
      if (load_p !== load_g) excl++;
      tick();
    end
    check({tag, "_load_p"}, lp, exp_lp);
    check({tag, "_shift"}, sh, 32'h2A8);
    check({tag, "_cnt_en"}, ce, 32'h2A8);
    check({tag, "_load_q"}, lq, 32'h2);
    check({tag, "_done"}, dn, 32'h400);
    check({tag, "_ready"}, rd, 32'h800);
    check({tag, "_excl"}, excl, 0);
    check({tag, "_product"}, {dp_p, dp_q}, {24'h0, exp_prod});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] lq, rd, dn;
    int sh;
    logic seen;

    // 1: asynchronous reset with no clock edge, then idle cycles
    #2 rst_n = 1'b0;
    #1 check("reset_async", {ready, ctl}, 10'h200);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_hold", {ready, ctl}, 10'h200);
    end

    // 2: 1011 x 1101 = 143, adds on iterations 1, 2, 4
    run_op("op_b_d", 4'b1011, 4'b1101, 32'h114, 8'h8F);

    // 3: zero multiplier, no adds
    run_op("op_0_f", 4'b0000, 4'b1111, 32'h0, 8'h00);

    // 4: Start held high for 30 cycles
    lq = 0; rd = 0; dn = 0;
    q_in = 4'b0011;
    r_in = 4'b0101;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      if (load_q) lq[k] = 1'b1;
      if (ready) rd[k] = 1'b1;
      if (done) dn[k] = 1'b1;
      tick();
    end
    start = 1'b0;
    check("b2b_load_q", lq, 32'h00801002);
    check("b2b_ready", rd, 32'h00400800);
    check("b2b_done", dn, 32'h00200400);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ready) seen = 1'b1;
      else tick();
    end
    check("b2b_return_idle", seen, 1'b1);
    check("b2b_product", {dp_p, dp_q}, 32'd15);

    // 5: reset during the 2nd SHIFT
    q_in = 4'b1011;
    r_in = 4'b1101;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_shift2", {shift, cnt_en}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_async", {ready, ctl}, 10'h200);
    seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("mid_no_done", seen, 1'b0);
    run_op("op_after_rst", 4'b1011, 4'b1101, 32'h114, 8'h8F);

    // 6: Cnt_Out stuck low
    force_cnt0 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef MULT_CU_WDOG_EN
    seen = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (error) seen = 1'b1;
      tick();
    end
    check("wdog_no_early_err", seen, 1'b0);
    check("wdog_error", {ready, ctl}, 10'h080);
    tick();
    check("wdog_error_hold", {ready, ctl}, 10'h080);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wdog_clear_idle", {ready, ctl}, 10'h200);
    tick();
    check("wdog_no_launch", {ready, ctl}, 10'h200);
`else
    seen = 1'b0;
    sh = 0;
    lq = 0;
    for (int k = 1; k <= 40; k++) begin
      if (error) seen = 1'b1;
      if (ready) lq[0] = 1'b1;
      if (shift) sh++;
      tick();
    end
    check("nowdog_error", seen, 1'b0);
    check("nowdog_ready", lq[0], 1'b0);
    check("nowdog_shifts", sh, 19);
`endif
    force_cnt0 = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("final_idle", {ready, ctl}, 10'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_control_unit.md
Name: mult_control_unit

Overview:
Control FSM for the 4-bit shift-add multiplier. It sits directly upstream of the multiplier datapath and drives its load, shift, count and clear strobes. It consumes the datapath's counter terminal flag and multiplier LSB, and gives the system a Start/Ready/Done handshake. One multiply is 4 add/shift iterations.

Parameters:
WDOG_LIMIT, 16, max ADD+SHIFT cycles per operation before watchdog error (used only with the optional feature); must be >= 8

Ports:
CU_Clock  input  1  system clock, rising-edge
CU_Reset_n  input  1  asynchronous active-low reset
CU_Start  input  1  request a multiply; sampled only in IDLE (and ERROR)
CU_Q_LSB  input  1  current LSB of datapath multiplier register
CU_Cnt_Out  input  1  datapath counter terminal flag; high while count == 3
CU_Ready  output  1  high in IDLE; block accepts Start
CU_Done  output  1  one-cycle pulse; product valid in datapath
CU_Error  output  1  watchdog fault flag
CU_Load_Q  output  1  load multiplier register
CU_Load_R  output  1  load multiplicand register
CU_Load_P  output  1  load adder sum into partial-product register
CU_Load_G  output  1  load adder carry into carry flop
CU_Shift  output  1  shift carry/P/Q right one bit
CU_Cnt_En  output  1  increment iteration counter
CU_Clear  output  1  active-high synchronous clear of P, carry, counter

Behaviour:
- Reset (CU_Reset_n=0): state forced to IDLE immediately, independent of the clock. While reset is held: CU_Ready=1, all other outputs 0. The watchdog counter is cleared.
- Outputs are combinational decodes of the state register. CU_Load_P and CU_Load_G additionally depend on CU_Q_LSB. There are no other combinational input-to-output paths.
- IDLE: Ready=1.
  - CU_Start=1 at the clock edge -> LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): Load_Q=Load_R=Clear=1 -> ADD.
  - Operands on the datapath inputs must be stable through this edge.
- ADD (1 cycle): Load_P=Load_G=CU_Q_LSB -> SHIFT.
  - When Q_LSB=0, no add occurs.
- SHIFT (1 cycle): Shift=1, Cnt_En=1.
  - CU_Cnt_Out=1 -> DONE (this was the 4th shift).
  - Otherwise -> ADD.
- DONE (1 cycle): Done=1 -> IDLE unconditionally. The product stays in the datapath until the next LOAD.
- Latency: Start sampled at edge N; LOAD in cycle N+1; ADD/SHIFT pairs in N+2..N+9; DONE in N+10; Ready again in N+11.
- Start outside IDLE/ERROR is ignored, with no queueing. Start held high continuously gives back-to-back operations with exactly one Ready cycle between DONE and the next LOAD.
- At most one of {Load_Q/Load_R/Clear group, Load_P/Load_G group, Shift/Cnt_En group} is high in any cycle.
- CU_Cnt_Out is ignored outside SHIFT.
- Illegal or unused state encodings -> IDLE on the next edge, with all controls 0 in that cycle.
- Reset mid-operation: controls drop asynchronously, and datapath contents are undefined afterwards. No Done is issued.

Optional Feature:
Macro MULT_CU_WDOG_EN.
- Defined:
  - A counter of width $clog2(WDOG_LIMIT+1) clears in LOAD and increments in each ADD and SHIFT cycle.
  - If it reaches WDOG_LIMIT while in ADD or SHIFT without a DONE transition, the next state is ERROR.
  - ERROR: Error=1, Ready=0, all datapath controls 0. CU_Start=1 -> IDLE; the Start is consumed and does not launch an operation.
  - CU_Error is 0 in every other state.
- Not defined: the counter and ERROR state are absent, CU_Error is tied 0, and the loop waits indefinitely for Cnt_Out.

Test Plan:
1. Assert CU_Reset_n=0 mid-cycle -> Ready=1 and all other outputs 0 without a clock edge. Release, then 5 idle clocks with Start=0 -> outputs unchanged.
2. Start pulse with a datapath model, Q=1011, R=1101; bench drives Q_LSB sequence 1,1,0,1 and Cnt_Out on the 4th SHIFT -> Load_P pulses in ADD iterations 1, 2, 4 only; 4 Shift pulses; Done in cycle N+10; product 143 (8'h8F).
3. Q=0000, R=1111 -> zero Load_P/Load_G pulses, 4 Shift/Cnt_En pulses, Done at N+10, product 0.
4. Start held high for 30 cycles -> Start during LOAD/ADD/SHIFT is ignored; exactly one Ready cycle between each DONE and the next LOAD (period 11 cycles).
5. Reset asserted during the 2nd SHIFT -> Shift/Cnt_En fall asynchronously, Ready=1, no Done. Next Start runs a full 11-cycle operation.
6. With MULT_CU_WDOG_EN and WDOG_LIMIT=16, Cnt_Out held 0 -> after 16 ADD/SHIFT cycles state is ERROR: Error=1, Ready=0. Start=1 -> IDLE with Error=0 and no LOAD. Without the macro, Error stays 0 and the loop keeps cycling.
